// File: rtl/xor_selftest_ctrl.sv
// Self-test sequencer for a 2-input XOR cell: sweeps all four {a,b} vectors,
// samples y after a settle window and records mismatches.
module xor_selftest_ctrl #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERRW   = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            a,
  output logic            b,
  input  logic            y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            fail_valid,
  output logic [1:0]      fail_vec
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int PW = (PASSES < 2) ? 1 : $clog2(PASSES);
  localparam bit HAS_WAIT = (SETTLE > 0);
  localparam logic [CW-1:0]   SETTLE_V  = CW'(SETTLE);
  localparam logic [PW-1:0]   LAST_PASS = PW'(PASSES - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   settle_cnt;
  logic [1:0]      vec;
  logic [PW-1:0]   pass_cnt;
  logic            exp_y;
  logic            mismatch;
  logic            last_vec;

  always_comb begin
    exp_y    = vec[1] ^ vec[0];
    mismatch = (y != exp_y);
    last_vec = (vec == 2'd3) && (pass_cnt == LAST_PASS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = HAS_WAIT ? WAIT : SAMPLE;
      end
      WAIT: begin
        busy = 1'b1;
        if (settle_cnt == CW'(1)) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy      = 1'b1;
        state_nxt = last_vec ? DONE : DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector, settle counter and result registers; pass is resolved on the
  // edge into DONE so it is already valid while done is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a          <= 1'b0;
      b          <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'b00;
      vec        <= 2'd0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'b00;
            pass       <= 1'b0;
            vec        <= 2'd0;
            pass_cnt   <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
          end
        end
        DRIVE: settle_cnt <= SETTLE_V;
        WAIT:  settle_cnt <= settle_cnt - CW'(1);
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERRW'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec;
            end
          end
          if (last_vec) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec <= vec + 2'd1;
            if (vec == 2'd3) pass_cnt <= pass_cnt + PW'(1);
            {a, b} <= vec + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_selftest_ctrl.sv
// Randomized bench for xor_selftest_ctrl: two instances (1 and 3 passes) checked
// every cycle against a run-timeline model, plus directed literal checks.
module tb_xor_selftest_ctrl;

  localparam int S  = 2;
  localparam int P0 = 1;
  localparam int P1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1, start0, start1;
  logic [3:0] fault0, fault1;
  logic       a0, b0, y0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [1:0] fvec0;
  logic       a1, b1, y1, busy1, done1, pass1, fv1;
  logic [1:0] err1;
  logic [1:0] fvec1;

  // fault bit set for a vector means the cell answers the wrong value there
  assign y0 = a0 ^ b0 ^ fault0[{a0, b0}];
  assign y1 = a1 ^ b1 ^ fault1[{a1, b1}];

  xor_selftest_ctrl #(.SETTLE(S), .PASSES(P0), .ERRW(4)) dut (
    .clk(clk), .reset_n(rst_n0), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_vec(fvec0));

  xor_selftest_ctrl #(.SETTLE(S), .PASSES(P1), .ERRW(2)) dut2 (
    .clk(clk), .reset_n(rst_n1), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_vec(fvec1));

  int errors = 0;
  int checks = 0;

  // Model: m_t is the cycle index inside a run (0 = not running,
  // 1..tot = busy, tot+1 = done cycle).
  int tot[2]  = '{4 * P0 * (S + 2), 4 * P1 * (S + 2)};
  int emax[2] = '{15, 3};
  int m_t[2]    = '{0, 0};
  int m_ab[2]   = '{0, 0};
  int m_err[2]  = '{0, 0};
  int m_fv[2]   = '{0, 0};
  int m_fvec[2] = '{0, 0};
  int m_pass[2] = '{0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_t[i] = 0; m_ab[i] = 0; m_err[i] = 0;
    m_fv[i] = 0; m_fvec[i] = 0; m_pass[i] = 0;
  endtask

  task automatic model_step(input int i, input bit st, input logic [3:0] flt);
    int p, sub, v;
    if (m_t[i] == 0) begin
      if (st) begin
        m_t[i] = 1; m_ab[i] = 0; m_err[i] = 0;
        m_fv[i] = 0; m_fvec[i] = 0; m_pass[i] = 0;
      end
    end else if (m_t[i] <= tot[i]) begin
      p   = m_t[i] - 1;
      sub = p % (S + 2);
      v   = (p / (S + 2)) % 4;
      if (sub == S + 1 && flt[v]) begin
        if (m_err[i] < emax[i]) m_err[i]++;
        if (m_fv[i] == 0) begin
          m_fv[i] = 1;
          m_fvec[i] = v;
        end
      end
      m_t[i]++;
      if (m_t[i] <= tot[i] && (m_t[i] - 1) % (S + 2) == 0)
        m_ab[i] = ((m_t[i] - 1) / (S + 2)) % 4;
      if (m_t[i] == tot[i] + 1) m_pass[i] = (m_err[i] == 0) ? 1 : 0;
    end else begin
      m_t[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n0) model_reset(0); else model_step(0, start0, fault0);
    if (!rst_n1) model_reset(1); else model_step(1, start1, fault1);
  end

  always @(negedge rst_n0) model_reset(0);
  always @(negedge rst_n1) model_reset(1);

  always @(negedge clk) begin
    chk("i0_busy", busy0, (m_t[0] >= 1 && m_t[0] <= tot[0]) ? 1 : 0);
    chk("i0_done", done0, (m_t[0] == tot[0] + 1) ? 1 : 0);
    chk("i0_ab", {a0, b0}, m_ab[0]);
    chk("i0_err", err0, m_err[0]);
    chk("i0_fv", fv0, m_fv[0]);
    chk("i0_fvec", fvec0, m_fvec[0]);
    chk("i0_pass", pass0, m_pass[0]);
    chk("i1_busy", busy1, (m_t[1] >= 1 && m_t[1] <= tot[1]) ? 1 : 0);
    chk("i1_done", done1, (m_t[1] == tot[1] + 1) ? 1 : 0);
    chk("i1_ab", {a1, b1}, m_ab[1]);
    chk("i1_err", err1, m_err[1]);
    chk("i1_fv", fv1, m_fv[1]);
    chk("i1_fvec", fvec1, m_fvec[1]);
    chk("i1_pass", pass1, m_pass[1]);
  end

  function automatic bit get_done(input int i);
    return (i == 0) ? done0 : done1;
  endfunction

  // Pulse start for one cycle on an idle instance; lat counts cycles from the
  // accepting edge to the cycle where done is high.
  task automatic run_time(input int i, output int lat);
    @(negedge clk);
    if (i == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (i == 0) start0 = 1'b0; else start1 = 1'b0;
    lat = 1;
    while (!get_done(i) && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 300) chk("run_timeout", 0, 1);
  endtask

  initial begin
    int lat, n, d1, d2, dcount;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    fault0 = 4'b0000; fault1 = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_a", a0, 0);
    chk("rst_b", b0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fvec", fvec0, 0);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    repeat (2) @(negedge clk);

    fault0 = 4'b0000;
    run_time(0, lat);
    chk("good_lat", lat, 17);
    chk("good_pass", pass0, 1);
    chk("good_err", err0, 0);
    chk("good_fv", fv0, 0);
    repeat (3) @(negedge clk);

    fault0 = 4'b0110;
    run_time(0, lat);
    chk("sa0_err", err0, 2);
    chk("sa0_fv", fv0, 1);
    chk("sa0_fvec", fvec0, 1);
    chk("sa0_pass", pass0, 0);
    repeat (3) @(negedge clk);

    fault0 = 4'b1111;
    run_time(0, lat);
    chk("xnor_lat", lat, 17);
    chk("xnor_err", err0, 4);
    chk("xnor_fvec", fvec0, 0);
    chk("xnor_pass", pass0, 0);
    repeat (3) @(negedge clk);

    fault1 = 4'b1111;
    run_time(1, lat);
    chk("sat_lat", lat, 49);
    chk("sat_err", err1, 3);
    chk("sat_pass", pass1, 0);
    repeat (3) @(negedge clk);

    fault0 = 4'b0000;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_a", a0, 1);
    chk("mid_b", b0, 0);
    chk("mid_busy", busy0, 1);
    #2 rst_n0 = 1'b0;
    @(negedge clk);
    chk("abort_a", a0, 0);
    chk("abort_b", b0, 0);
    chk("abort_busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst_n0 = 1'b1;
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    chk("abort_nodone", dcount, 0);
    run_time(0, lat);
    chk("restart_pass", pass0, 1);
    repeat (3) @(negedge clk);

    n = 0; d1 = -1; d2 = -1;
    @(negedge clk); start0 = 1'b1;
    while (d2 < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (done0) begin
        if (d1 < 0) d1 = n; else d2 = n;
      end
    end
    start0 = 1'b0;
    chk("hold_first", d1, 17);
    chk("hold_gap", d2 - d1, 18);
    repeat (40) @(negedge clk);

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst_n0 = 1'b1;
      rst_n1 = 1'b1;
      start0 = ($urandom_range(0, 3) == 0);
      start1 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) fault0 = 4'($urandom);
      if ($urandom_range(0, 15) == 0) fault1 = 4'($urandom);
      if ($urandom_range(0, 399) == 0) #2 rst_n0 = 1'b0;
      if ($urandom_range(0, 399) == 0) #2 rst_n1 = 1'b0;
    end
    @(negedge clk);
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
